// File: rtl/ende_pulse_sequencer.sv
// Avalon-MM pulse-train sequencer for a single enable line.
// Software programs ON/OFF lengths and a repeat count, then writes START.
// The block then drives en_out through ON/OFF phases autonomously.
module ende_pulse_sequencer #(
  parameter int CNT_W = 16,
  parameter int REP_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        en_out,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0] REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] on_q, off_q;
  logic [REP_W-1:0] rep_q;
  logic [CNT_W-1:0] on_sh_q, off_sh_q;
  logic             rep_inf_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] pulses_q, pulses_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             irq_en_q, irq_en_d;
  logic             en_q, irq_q;

  logic wr, ctrl_wr, start_cmd, stop_cmd, clr_cmd;
  logic start_go, finish;
  logic [CNT_W-1:0] on_len_cfg, on_len_sh, off_len_sh;

  assign wr        = chipselect & ~write_n;
  assign ctrl_wr   = wr && (address == 2'd0);
  assign start_cmd = ctrl_wr & writedata[0];
  assign stop_cmd  = ctrl_wr & writedata[1];
  assign clr_cmd   = ctrl_wr & writedata[3];

  // A programmed length of zero behaves like one cycle.
  assign on_len_cfg = (on_q == '0)     ? CNT_ONE : on_q;
  assign on_len_sh  = (on_sh_q == '0)  ? CNT_ONE : on_sh_q;
  assign off_len_sh = (off_sh_q == '0) ? CNT_ONE : off_sh_q;

  // START only takes effect from IDLE and loses to a simultaneous STOP.
  assign start_go = start_cmd & ~stop_cmd & (state_q == S_IDLE);
  // Last cycle of the final ON pulse of a finite sequence.
  assign finish   = (state_q == S_ON) && (cnt_q == CNT_ONE) && !rep_inf_q &&
                    (pulses_q == REP_ONE) && !stop_cmd;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic, including phase and pulse counters
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pulses_d = pulses_q;
    case (state_q)
      S_IDLE: begin
        if (start_go) begin
          state_d  = S_ON;
          cnt_d    = on_len_cfg;
          pulses_d = rep_q;
        end
      end
      S_ON: begin
        if (cnt_q == CNT_ONE) begin
          // Infinite mode never decrements, so the counter cannot wrap.
          if (!rep_inf_q) pulses_d = pulses_q - REP_ONE;
          if (!rep_inf_q && pulses_q == REP_ONE) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_OFF;
            cnt_d   = off_len_sh;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_OFF: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_ON;
          cnt_d   = on_len_sh;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (stop_cmd) state_d = S_IDLE;
  end

  // Status flag next values; completion set has priority over DONE_CLR
  always_comb begin
    done_d    = done_q;
    aborted_d = aborted_q;
    irq_en_d  = ctrl_wr ? writedata[2] : irq_en_q;
    if (clr_cmd)  begin done_d = 1'b0; aborted_d = 1'b0; end
    if (start_go) done_d = 1'b0;
    if (finish)   done_d = 1'b1;
    if (stop_cmd && state_q != S_IDLE) aborted_d = 1'b1;
  end

  // Datapath registers: config, shadows, counters, flags, registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      on_q      <= '0;
      off_q     <= '0;
      rep_q     <= '0;
      on_sh_q   <= '0;
      off_sh_q  <= '0;
      rep_inf_q <= 1'b0;
      cnt_q     <= '0;
      pulses_q  <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      irq_en_q  <= 1'b0;
      en_q      <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (wr && address == 2'd1) on_q  <= writedata[CNT_W-1:0];
      if (wr && address == 2'd2) off_q <= writedata[CNT_W-1:0];
      if (wr && address == 2'd3) rep_q <= writedata[REP_W-1:0];
      if (start_go) begin
        on_sh_q   <= on_q;
        off_sh_q  <= off_q;
        rep_inf_q <= (rep_q == '0);
      end
      cnt_q     <= cnt_d;
      pulses_q  <= pulses_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      irq_en_q  <= irq_en_d;
      en_q      <= (state_d == S_ON);
      irq_q     <= done_d & irq_en_d;
    end
  end

  // Output logic: zero-wait read mux and registered pins
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[3:0] = {aborted_q, irq_en_q, done_q, (state_q != S_IDLE)};
      2'd1: readdata[CNT_W-1:0] = on_q;
      2'd2: readdata[CNT_W-1:0] = off_q;
      2'd3: readdata[REP_W-1:0] = rep_q;
      default: readdata = '0;
    endcase
    en_out = en_q;
    irq    = irq_q;
  end

endmodule

// File: tb/tb_ende_pulse_sequencer.sv
// Directed bench for ende_pulse_sequencer: inputs change 1ns after the
// rising edge, outputs are sampled there too.
module tb_ende_pulse_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        en_out;
  logic        irq;

  int errors = 0;
  int checks = 0;

  ende_pulse_sequencer #(.CNT_W(16), .REP_W(16)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .en_out(en_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle write; returns 1ns into the following cycle.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address = a; #1; v = readdata;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  pat;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", en_out, 0);
    chk("rst_irq", irq, 0);
    reset = 1'b0;
    step();
    rd(0, v); chk("rst_ctrl", v, 0);

    // T1: reset while running
    wr(1, 100); wr(3, 0); wr(0, 1);
    step(); step();
    chk("t1_running", en_out, 1);
    reset = 1'b1; #1;
    chk("t1_async_drop", en_out, 0);
    step(); step();
    reset = 1'b0;
    step();
    rd(0, v); chk("t1_ctrl_after", v, 0);
    rd(1, v); chk("t1_on_cleared", v, 0);

    // T2: ON=3 OFF=2 REPEAT=2, irq enabled
    wr(1, 3); wr(2, 2); wr(3, 2); wr(0, 32'h5);
    pat = 8'b11100111;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_en_%0d", i + 1), en_out, pat[7-i]);
      step();
    end
    chk("t2_en_9", en_out, 0);
    rd(0, v); chk("t2_ctrl_done", v, 32'h6);
    chk("t2_irq", irq, 1);
    wr(0, 32'hC);
    rd(0, v); chk("t2_ctrl_clr", v, 32'h4);

    // T3: zero lengths clamp to one cycle
    wr(1, 0); wr(2, 0); wr(3, 3); wr(0, 32'h5);
    pat = 8'b10101000;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_en_%0d", i + 1), en_out, pat[7-i]);
      step();
    end
    rd(0, v); chk("t3_ctrl_done", v, 32'h6);
    wr(0, 32'h8);

    // T4: continuous mode, STOP during cycle N+20
    wr(3, 0); wr(1, 4); wr(2, 4); wr(0, 32'h1);
    for (int k = 1; k <= 20; k++) begin
      chk($sformatf("t4_en_%0d", k), en_out, (((k - 1) % 8) < 4) ? 1 : 0);
      if (k < 20) step();
    end
    wr(0, 32'h2);
    chk("t4_en_after_stop", en_out, 0);
    rd(0, v); chk("t4_ctrl_aborted", v, 32'h8);
    wr(0, 32'h8);
    rd(0, v); chk("t4_ctrl_clr", v, 0);

    // T5a: START+STOP together from IDLE
    wr(0, 32'h3);
    chk("t5a_en", en_out, 0);
    rd(0, v); chk("t5a_ctrl", v, 0);

    // T5b: START while busy and ON rewrite mid-run
    wr(1, 3); wr(2, 2); wr(3, 2); wr(0, 32'h1);
    chk("t5b_en_1", en_out, 1);
    wr(0, 32'h1);
    chk("t5b_en_2", en_out, 1);
    wr(1, 9);
    chk("t5b_en_3", en_out, 1);
    pat = 8'b00111000;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t5b_en_%0d", i + 4), en_out, pat[7-i]);
    end
    rd(0, v); chk("t5b_ctrl_done", v, 32'h2);

    // T5c: next START picks up ON=9
    rd(1, v); chk("t5c_on_reg", v, 9);
    wr(0, 32'h1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t5c_en_%0d", i + 1), en_out, (i < 9) ? 1 : 0);
      step();
    end
    wr(0, 32'h2);
    rd(0, v); chk("t5c_ctrl_stop", v, 32'h8);
    wr(0, 32'h8);

    // T6: DONE_CLR in the completion cycle, then one cycle later
    wr(1, 2); wr(2, 1); wr(3, 1); wr(0, 32'h5);
    chk("t6_en_1", en_out, 1);
    step();
    chk("t6_en_2", en_out, 1);
    wr(0, 32'hC);
    rd(0, v); chk("t6_done_kept", v, 32'h6);
    chk("t6_irq_kept", irq, 1);
    wr(0, 32'hC);
    rd(0, v); chk("t6_done_clr", v, 32'h4);
    chk("t6_irq_clr", irq, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
